// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: 32-iteration shift-add multiply and restoring divide,
// MTHI/MTLO write port, and pipeline stall generation while the unit is busy.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hl_read,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] opnd;     // multiplicand (multiply) or divisor (divide)
  logic [31:0] acc_hi;   // upper product half / partial remainder
  logic [31:0] acc_lo;   // multiplier shift register / quotient
  logic        neg_a;
  logic        neg_b;
  logic        zero_div;

  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [31:0] div_diff;
  logic        div_ok;
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    abs_a    = (~op[0] & src_a[31]) ? 32'd0 - src_a : src_a;
    abs_b    = (~op[0] & src_b[31]) ? 32'd0 - src_b : src_b;
    mul_sum  = {1'b0, acc_hi} + {1'b0, opnd};
    div_sh   = {acc_hi, acc_lo[31]};
    div_ok   = div_sh >= {1'b0, opnd};
    // Partial remainder stays below 2*divisor, so a non-borrowing difference fits 32 bits.
    div_diff = div_sh[31:0] - opnd;
    prod     = {acc_hi, acc_lo};
    prod_fix = (~op_q[0] & (neg_a ^ neg_b)) ? 64'd0 - prod : prod;
    quo_fix  = (~op_q[0] & (neg_a ^ neg_b)) ? 32'd0 - acc_lo : acc_lo;
    rem_fix  = (~op_q[0] & neg_a) ? 32'd0 - acc_hi : acc_hi;
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hl_read | mthi | mtlo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      zero_div <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wr_data;
          if (mtlo) lo <= wr_data;
          if (start && !flush) begin
            op_q     <= op;
            opnd     <= op[1] ? abs_b : abs_a;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? abs_a : abs_b;
            neg_a    <= ~op[0] & src_a[31];
            neg_b    <= ~op[0] & src_b[31];
            zero_div <= (src_b == 32'd0);
            cnt      <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 5'd1;
            if (op_q[1]) begin
              acc_hi <= div_ok ? div_diff : div_sh[31:0];
              acc_lo <= {acc_lo[30:0], div_ok};
            end else if (acc_lo[0]) begin
              acc_hi <= mul_sum[32:1];
              acc_lo <= {mul_sum[0], acc_lo[31:1]};
            end else begin
              acc_hi <= {1'b0, acc_hi[31:1]};
              acc_lo <= {acc_hi[0], acc_lo[31:1]};
            end
            if (cnt == 5'd31) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (op_q[1]) begin
              if (zero_div) begin
                div_zero <= 1'b1;
              end else begin
                lo <= quo_fix;
                hi <= rem_fix;
              end
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand-written corner
// sequences, and randomized operations checked against an arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk, rst_n, start, hl_read, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wr_data;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hl_read(hl_read), .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns {div_zero, hi, lo} from plain signed/unsigned arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, b,
                                        input logic [31:0] ph, pl);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; return {1'b0, p}; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd2: begin
        if (b == 32'd0) return {1'b1, ph, pl};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {1'b0, r, q};
      end
      default: begin
        if (b == 32'd0) return {1'b1, ph, pl};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a, b,
                           input logic [31:0] eh, el, input logic edz);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_ok);
    chk({name, "_latency"}, 64'(lat), 64'd33);
    chk({name, "_busy_run"}, 64'(busy_ok), 64'd1);
    chk({name, "_busy_end"}, 64'(busy), 64'd0);
    chk({name, "_divzero"}, 64'(div_zero), 64'(edz));
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int          lat;
    logic        busy_ok, seen;
    logic [64:0] r;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vecs.push_back('{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0});
    vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{2'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0});

    rst_n = 1'b0; start = 0; op = 0; src_a = 0; src_b = 0;
    hl_read = 0; mthi = 0; mtlo = 0; wr_data = 0; flush = 0;
    #12;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_divzero", 64'(div_zero), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // MTHI/MTLO preload, then DIVU by zero leaves HI/LO intact.
    @(negedge clk); mthi = 1; wr_data = 32'h11;
    @(negedge clk); mthi = 0; mtlo = 1; wr_data = 32'h22;
    @(negedge clk); mtlo = 0;
    chk("mt_hi", 64'(hi), 64'h11);
    chk("mt_lo", 64'(lo), 64'h22);
    m_hi = 32'h11; m_lo = 32'h22;
    run_check("divu_zero", 2'd3, 32'd100, 32'd0, 32'h11, 32'h22, 1'b1);

    // DIVU 100/7 with hl_read and a second start held through busy.
    @(negedge clk); op = 2'd3; src_a = 32'd100; src_b = 32'd7; start = 1; hl_read = 1;
    @(negedge clk); op = 2'd1; src_a = 32'd6; src_b = 32'd7;
    lat = 0;
    while (!done && lat < 40) begin
      chk("stall_busy", 64'(stall), 64'd1);
      @(negedge clk);
      lat++;
    end
    chk("hold_latency", 64'(lat), 64'd33);
    chk("hold_stall_end", 64'(stall), 64'd0);
    chk("hold_hi", 64'(hi), 64'd2);
    chk("hold_lo", 64'(lo), 64'd14);
    @(negedge clk); start = 0; hl_read = 0;
    chk("second_accept", 64'(busy), 64'd1);
    wait_done(lat, busy_ok);
    chk("second_latency", 64'(lat), 64'd33);
    chk("second_hi", 64'(hi), 64'd0);
    chk("second_lo", 64'(lo), 64'd42);
    m_hi = 32'd0; m_lo = 32'd42;

    // Flush at E10 aborts without writing HI/LO.
    @(negedge clk); op = 2'd1; src_a = 32'd5; src_b = 32'd5; start = 1;
    @(negedge clk); start = 0;
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk); flush = 0;
    chk("flush_idle", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_hi", 64'(hi), 64'(m_hi));
    chk("flush_lo", 64'(lo), 64'(m_lo));
    @(negedge clk); mthi = 1; wr_data = 32'h1234;
    @(negedge clk); mthi = 0;
    chk("mthi_after_flush", 64'(hi), 64'h1234);
    chk("lo_after_mthi", 64'(lo), 64'(m_lo));
    m_hi = 32'h1234;

    // Flush in IDLE drops the start but keeps the MTLO write.
    @(negedge clk); op = 2'd1; src_a = 5; src_b = 5; start = 1; flush = 1; mtlo = 1; wr_data = 32'h55;
    @(negedge clk); start = 0; flush = 0; mtlo = 0;
    chk("idle_flush_busy", 64'(busy), 64'd0);
    chk("idle_flush_mtlo", 64'(lo), 64'h55);
    m_lo = 32'h55;

    // Start and MTHI together: MT value visible now, overwritten at FIX.
    @(negedge clk); op = 2'd1; src_a = 2; src_b = 3; start = 1; mthi = 1; wr_data = 32'h99;
    @(negedge clk); start = 0; mthi = 0;
    chk("start_mthi_hi", 64'(hi), 64'h99);
    chk("start_mthi_busy", 64'(busy), 64'd1);
    wait_done(lat, busy_ok);
    chk("start_mthi_lat", 64'(lat), 64'd33);
    chk("start_mthi_fix_hi", 64'(hi), 64'd0);
    chk("start_mthi_fix_lo", 64'(lo), 64'd6);
    m_hi = 0; m_lo = 6;

    // Async reset at E20 of a MULT.
    @(negedge clk); mthi = 1; wr_data = 32'hAAAA;
    @(negedge clk); mthi = 0;
    @(negedge clk); op = 2'd0; src_a = 32'h1234_5678; src_b = 32'd9; start = 1;
    @(negedge clk); start = 0;
    repeat (19) @(negedge clk);
    @(posedge clk); #1 rst_n = 0;
    #1;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clk); rst_n = 1;
    m_hi = 0; m_lo = 0;
    run_check("post_rst_multu", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 20)); end
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      r = model(ro, ra, rb, m_hi, m_lo);
      run_check($sformatf("rand%0d_op%0d", k, ro), ro, ra, rb, r[63:32], r[31:0], r[64]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
